// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   tx_state_t : transmitter state encoding
//   DATA_BITS  : data bits per frame
//   STOP_BITS  : stop bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    s_IDLE         = 2'd0,
    s_TX_START_BIT = 2'd1,
    s_TX_DATA_BITS = 2'd2,
    s_TX_STOP_BIT  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO that feeds the UART transmitter.
// Ports:
//   i_Clock, i_Reset : clock, asynchronous active-high reset
//   i_Push, i_Data   : write request and byte (ignored while full)
//   i_Pop            : read request (ignored while empty)
//   o_Data           : head-of-queue byte
//   o_Full, o_Empty  : status flags, decoded from the registered count
//   o_Count          : number of stored bytes
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Push,
  input  logic [DATA_BITS-1:0]   i_Data,
  input  logic                   i_Pop,
  output logic [DATA_BITS-1:0]   o_Data,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] r_Mem [DEPTH];
  logic [AW-1:0]        r_Wr_Ptr;
  logic [AW-1:0]        r_Rd_Ptr;
  logic [AW:0]          r_Count;
  logic                 w_Push_Ok;
  logic                 w_Pop_Ok;

  // A push while full is dropped even when a pop happens in the same cycle.
  assign o_Full    = (r_Count == FULL_COUNT);
  assign o_Empty   = (r_Count == {(AW+1){1'b0}});
  assign w_Push_Ok = i_Push & ~o_Full;
  assign w_Pop_Ok  = i_Pop & ~o_Empty;
  assign o_Data    = r_Mem[r_Rd_Ptr];
  assign o_Count   = r_Count;

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge i_Clock) begin
    if (w_Push_Ok) begin
      r_Mem[r_Wr_Ptr] <= i_Data;
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of 2) and occupancy count.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Wr_Ptr <= {AW{1'b0}};
      r_Rd_Ptr <= {AW{1'b0}};
      r_Count  <= {(AW+1){1'b0}};
    end else begin
      if (w_Push_Ok) begin
        r_Wr_Ptr <= r_Wr_Ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_Pop_Ok) begin
        r_Rd_Ptr <= r_Rd_Ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_Push_Ok, w_Pop_Ok})
        2'b10:   r_Count <= r_Count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_Count <= r_Count - {{AW{1'b0}}, 1'b1};
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Queued bytes are sent back-to-back with no idle gap between frames.
// Ports:
//   i_Clock, i_Reset        : clock, asynchronous active-high reset
//   i_Tx_DV, i_Tx_Byte      : write strobe and byte, taken when o_Tx_Ready=1
//   o_Tx_Ready              : FIFO not full
//   o_Tx_Serial             : registered serial line, idles high
//   o_Tx_Active             : high from first start-bit clock to last stop-bit clock
//   o_Tx_Done               : one-cycle pulse on the last clock of each stop bit
//   o_Fifo_Count            : number of queued bytes
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            r_State;
  tx_state_t            w_Next_State;
  logic [CW-1:0]        r_Clk_Count;
  logic [CW-1:0]        w_Next_Clk;
  logic [2:0]           r_Bit_Index;
  logic [2:0]           w_Next_Bit;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 w_Pop;
  logic [DATA_BITS-1:0] w_Fifo_Data;
  logic                 w_Full;
  logic                 w_Empty;
  logic                 r_Tx_Serial;
  logic                 r_Tx_Active;
  logic                 r_Tx_Done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Tx_DV),
    .i_Data  (i_Tx_Byte),
    .i_Pop   (w_Pop),
    .o_Data  (w_Fifo_Data),
    .o_Full  (w_Full),
    .o_Empty (w_Empty),
    .o_Count (o_Fifo_Count)
  );

  assign o_Tx_Ready  = ~w_Full;
  assign o_Tx_Serial = r_Tx_Serial;
  assign o_Tx_Active = r_Tx_Active;
  assign o_Tx_Done   = r_Tx_Done;

  // State, bit timer, bit index and shift register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= s_IDLE;
      r_Clk_Count <= {CW{1'b0}};
      r_Bit_Index <= 3'd0;
      r_Shift     <= {DATA_BITS{1'b0}};
    end else begin
      r_State     <= w_Next_State;
      r_Clk_Count <= w_Next_Clk;
      r_Bit_Index <= w_Next_Bit;
      if (w_Pop) begin
        r_Shift <= w_Fifo_Data;
      end
    end
  end

  // Next-state logic; the head byte is popped when entering START, either
  // from IDLE or from the final stop-bit clock so frames stay contiguous.
  always_comb begin
    w_Next_State = r_State;
    w_Next_Clk   = r_Clk_Count;
    w_Next_Bit   = r_Bit_Index;
    w_Pop        = 1'b0;
    case (r_State)
      s_IDLE: begin
        w_Next_Clk = {CW{1'b0}};
        w_Next_Bit = 3'd0;
        if (!w_Empty) begin
          w_Pop        = 1'b1;
          w_Next_State = s_TX_START_BIT;
        end else begin
          w_Next_State = s_IDLE;
        end
      end
      s_TX_START_BIT: begin
        if (r_Clk_Count == LAST_CLK) begin
          w_Next_Clk   = {CW{1'b0}};
          w_Next_Bit   = 3'd0;
          w_Next_State = s_TX_DATA_BITS;
        end else begin
          w_Next_Clk   = r_Clk_Count + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      s_TX_DATA_BITS: begin
        if (r_Clk_Count == LAST_CLK) begin
          w_Next_Clk = {CW{1'b0}};
          if (r_Bit_Index == LAST_BIT) begin
            w_Next_Bit   = 3'd0;
            w_Next_State = s_TX_STOP_BIT;
          end else begin
            w_Next_Bit   = r_Bit_Index + 3'd1;
          end
        end else begin
          w_Next_Clk = r_Clk_Count + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      s_TX_STOP_BIT: begin
        if (r_Clk_Count == LAST_CLK) begin
          w_Next_Clk = {CW{1'b0}};
          if (!w_Empty) begin
            w_Pop        = 1'b1;
            w_Next_State = s_TX_START_BIT;
          end else begin
            w_Next_State = s_IDLE;
          end
        end else begin
          w_Next_Clk = r_Clk_Count + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_Next_State = s_IDLE;
        w_Next_Clk   = {CW{1'b0}};
        w_Next_Bit   = 3'd0;
      end
    endcase
  end

  // Registered line outputs, decoded from the current state, so the line
  // trails the state register by exactly one clock for every bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      case (r_State)
        s_TX_START_BIT: r_Tx_Serial <= 1'b0;
        s_TX_DATA_BITS: r_Tx_Serial <= r_Shift[r_Bit_Index];
        default:        r_Tx_Serial <= 1'b1;
      endcase
      r_Tx_Active <= (r_State != s_IDLE);
      r_Tx_Done   <= (r_State == s_TX_STOP_BIT) && (r_Clk_Count == LAST_CLK);
    end
  end

endmodule
